// File: rtl/qynq_led_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qynq_led_ctrl: debounced GPIO press steps LEDs OFF/STEADY/BLINK/CHASE |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module qynq_led_ctrl #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned BLINK_TICKS = 1,
  parameter int unsigned CHASE_TICKS = 1,
  parameter int unsigned BRIGHT      = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gpio_i,
  input  logic       en_i,
  output logic [3:0] led_o,
  output logic [1:0] mode_o
);

  localparam int unsigned c_db_w    = $clog2(DB_CYCLES + 1);
  localparam int unsigned c_presc_w = $clog2(TICK_DIV);
  localparam int unsigned c_blink_w = $clog2(BLINK_TICKS + 1);
  localparam int unsigned c_chase_w = $clog2(CHASE_TICKS + 1);

  localparam logic [c_db_w-1:0]    c_db_last    = c_db_w'(DB_CYCLES - 1);
  localparam logic [c_db_w-1:0]    c_db_one     = c_db_w'(1);
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
  localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_TICKS - 1);
  localparam logic [c_blink_w-1:0] c_blink_one  = c_blink_w'(1);
  localparam logic [c_chase_w-1:0] c_chase_last = c_chase_w'(CHASE_TICKS - 1);
  localparam logic [c_chase_w-1:0] c_chase_one  = c_chase_w'(1);
  localparam logic [7:0]           c_bright     = 8'(BRIGHT);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_t;

  logic                 r_sync_meta;
  logic                 r_sync;
  logic                 r_db;
  logic [c_db_w-1:0]    r_db_cnt;
  logic                 r_db_prev;
  logic                 r_adv;

  mode_t                r_mode;
  mode_t                w_mode_nxt;
  logic                 w_mode_chg;

  logic [c_presc_w-1:0] r_presc;
  logic                 w_tick;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_on;
  logic [c_chase_w-1:0] r_chase_cnt;
  logic [3:0]           r_chase;
  logic [7:0]           r_pwm_cnt;

  logic [3:0]           w_led_nxt;
  logic [3:0]           r_led;

  // Input synchroniser, debouncer and rising-edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
      r_db        <= 1'b0;
      r_db_cnt    <= '0;
      r_db_prev   <= 1'b0;
      r_adv       <= 1'b0;
    end else begin
      r_sync_meta <= gpio_i;
      r_sync      <= r_sync_meta;
      if (r_sync == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_last) begin
        r_db     <= r_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_db_one;
      end
      r_db_prev <= r_db;
      r_adv     <= r_db & ~r_db_prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_OFF;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // A press while disabled is dropped, not remembered
  always_comb begin
    w_mode_nxt = r_mode;
    w_mode_chg = 1'b0;
    if (r_adv && en_i) begin
      w_mode_chg = 1'b1;
      case (r_mode)
        MODE_OFF:    w_mode_nxt = MODE_STEADY;
        MODE_STEADY: w_mode_nxt = MODE_BLINK;
        MODE_BLINK:  w_mode_nxt = MODE_CHASE;
        default:     w_mode_nxt = MODE_OFF;
      endcase
    end
  end

  assign w_tick = en_i && (r_presc == c_presc_last);

  // Mode change restarts the pattern and swallows a coincident tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_chase_cnt <= '0;
      r_chase     <= 4'b0001;
    end else if (w_mode_chg) begin
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_chase_cnt <= '0;
      r_chase     <= 4'b0001;
    end else if (en_i) begin
      r_presc <= w_tick ? '0 : (r_presc + c_presc_one);
      if (w_tick && (r_mode == MODE_BLINK)) begin
        if (r_blink_cnt == c_blink_last) begin
          r_blink_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_blink_one;
        end
      end
      if (w_tick && (r_mode == MODE_CHASE)) begin
        if (r_chase_cnt == c_chase_last) begin
          r_chase_cnt <= '0;
          r_chase     <= {r_chase[2:0], r_chase[3]};
        end else begin
          r_chase_cnt <= r_chase_cnt + c_chase_one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  always_comb begin
    w_led_nxt = 4'b0000;
    if (en_i) begin
      case (r_mode)
        MODE_STEADY: w_led_nxt = (r_pwm_cnt < c_bright) ? 4'b1111 : 4'b0000;
        MODE_BLINK:  w_led_nxt = r_blink_on ? 4'b1111 : 4'b0000;
        MODE_CHASE:  w_led_nxt = r_chase;
        default:     w_led_nxt = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= 4'b0000;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign led_o  = r_led;
  assign mode_o = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_qynq_led_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_qynq_led_ctrl: random + directed bench against an arithmetic model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_qynq_led_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int DB_CYCLES   = 3;
  localparam int BLINK_TICKS = 2;
  localparam int CHASE_TICKS = 1;
  localparam int BRIGHT      = 128;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       gpio  = 1'b0;
  logic       en    = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  qynq_led_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DB_CYCLES  (DB_CYCLES),
    .BLINK_TICKS(BLINK_TICKS),
    .CHASE_TICKS(CHASE_TICKS),
    .BRIGHT     (BRIGHT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gpio_i(gpio),
    .en_i  (en),
    .led_o (led),
    .mode_o(mode)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode as an integer, pattern derived from the count of
  // enabled cycles spent in the current mode, pwm from cycles since reset.
  int         m_g1, m_sync, m_db, m_db_prev, m_adv, m_mode, m_e, m_pwm;
  int         m_win[DB_CYCLES];
  int         all_diff, nxt_adv, mode_chg;
  logic [3:0] m_led, nxt_led;

  function automatic logic [3:0] exp_pattern(input int md, input int e, input int pwm);
    case (md)
      1:       return (pwm < BRIGHT) ? 4'hF : 4'h0;
      2:       return (((e / (TICK_DIV * BLINK_TICKS)) % 2) == 0) ? 4'hF : 4'h0;
      3:       return 4'(1 << ((e / (TICK_DIV * CHASE_TICKS)) % 4));
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_g1 = 0; m_sync = 0; m_db = 0; m_db_prev = 0; m_adv = 0;
      m_mode = 0; m_e = 0; m_pwm = 0; m_led = 4'h0;
      foreach (m_win[i]) m_win[i] = 0;
    end else begin
      nxt_led  = en ? exp_pattern(m_mode, m_e, m_pwm) : 4'h0;
      mode_chg = (m_adv != 0 && en) ? 1 : 0;
      for (int i = DB_CYCLES - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = m_sync;
      all_diff = 1;
      foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 0;
      nxt_adv   = (m_db == 1 && m_db_prev == 0) ? 1 : 0;
      m_db_prev = m_db;
      if (all_diff != 0) m_db = 1 - m_db;
      m_adv  = nxt_adv;
      m_sync = m_g1;
      m_g1   = int'(gpio);
      if (mode_chg != 0) begin
        m_mode = (m_mode + 1) % 4;
        m_e    = 0;
      end else if (en) begin
        m_e++;
      end
      m_pwm = (m_pwm + 1) % 256;
      m_led = nxt_led;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_val("led", int'(led), int'(m_led));
      check_val("mode", int'(mode), m_mode);
    end
  end

  task automatic step(input logic g, input logic e, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      gpio = g;
      en   = e;
    end
  endtask

  task automatic press(input logic e);
    step(1'b1, e, 8);
    step(1'b0, e, 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    logic g, e;
    int len;

    rst_n = 1'b0; gpio = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_led", int'(led), 0);
    check_val("rst_mode", int'(mode), 0);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;

    step(1'b0, 1'b1, 50);
    check_val("idle_mode", int'(mode), 0);

    @(negedge clk);
    #1 gpio = 1'b1;
    n = 0;
    while (mode != 2'd1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("press_latency", n, 7);

    repeat (4) @(negedge clk);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (led == 4'hF) hi++;
    end
    check_val("steady_duty", hi, 128);

    step(1'b0, 1'b1, 10);
    step(1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 20);
    check_val("glitch_mode", int'(mode), 1);

    press(1'b1);
    check_val("blink_mode", int'(mode), 2);
    step(1'b0, 1'b1, 40);

    press(1'b1);
    check_val("chase_mode", int'(mode), 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led != 4'b0100 && n < 40);
    check_val("chase_reach", int'(led), 4);
    #1 en = 1'b0;
    press(1'b0);
    check_val("hold_led", int'(led), 0);
    check_val("hold_mode", int'(mode), 3);
    @(negedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    check_val("resume_led", int'(led), 4);

    press(1'b1);
    check_val("wrap_mode", int'(mode), 0);
    check_val("wrap_led", int'(led), 0);

    repeat (400) begin
      g   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      e   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        #1 rst_n = 1'b0;
        step(g, e, len);
        @(negedge clk);
        #1 rst_n = 1'b1;
      end else begin
        step(g, e, len);
      end
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
